// File: rtl/jpeg_pkg.sv
// Shared types and helpers for the JPEG front end.
// Channel ids, read-FSM states, clog2 and level-shift helpers.
package jpeg_pkg;

    localparam int CH_Y  = 0;
    localparam int CH_CB = 1;
    localparam int CH_CR = 2;

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_LOAD    = 2'd1,
        RD_STREAM  = 2'd2,
        RD_NEXT_CH = 2'd3
    } rd_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Subtract mid-scale; the 64-bit difference is already
    // sign-extended, bits at and above ow are cleared.
    function automatic logic [63:0] level_shift(
        input logic [63:0] value,
        input int          iw,
        input int          ow
    );
        logic [63:0] r;
        r = value - (64'd1 << (iw - 1));
        for (int i = 0; i < 64; i++) begin
            if (i >= ow) r[i] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/jpeg_planar_block_buffer_axis_out_reg.sv
// 1-deep AXI-Stream register slice carrying data, user and last.
// Ports: in_* upstream side (in_ready = load enable), out_* downstream.
module axis_out_reg #(
    parameter int DW = 32,
    parameter int UW = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic [UW-1:0] in_user,
    input  logic          in_last,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [UW-1:0] out_user,
    output logic          out_last,
    input  logic          out_ready
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic [UW-1:0] user_q, user_d;
    logic          last_q, last_d;

    assign in_ready = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        user_d  = user_q;
        last_d  = last_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
                user_d = in_user;
                last_d = in_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            user_q  <= user_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_user  = user_q;
    assign out_last  = last_q;

endmodule

// File: rtl/jpeg_planar_block_buffer.sv
// Ping-pong block buffer: interleaved pixels in, planar channels out.
// Ports: s_axis_* pixel input, m_axis_* planar output, cfg_* per-block
// options, err_* one-cycle tlast error pulses, blocks_out block count.
module jpeg_planar_block_buffer
    import jpeg_pkg::*;
#(
    parameter int INPUT_WIDTH = 8,
    parameter int NUM_CH      = 3,
    parameter int DATA_DEPTH  = 8,
    parameter int OUT_WIDTH   = 32,
    parameter int CH_W        = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_CH*INPUT_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [OUT_WIDTH-1:0]          m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [CH_W-1:0]               m_axis_tuser,
    input  logic                          cfg_transpose,
    input  logic                          cfg_level_shift,
    input  logic [NUM_CH-1:0]             cfg_ch_mask,
    output logic                          err_tlast_early,
    output logic                          err_tlast_miss,
    output logic [15:0]                   blocks_out
);

    localparam int PIXEL_COUNT = DATA_DEPTH * DATA_DEPTH;
    localparam int PIX_W =
        (PIXEL_COUNT > 1) ? clog2(PIXEL_COUNT) : 1;
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXEL_COUNT - 1);

    logic [INPUT_WIDTH-1:0] mem_q [2][NUM_CH][PIXEL_COUNT];

    logic              alive_q, alive_d;
    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [PIX_W-1:0]  wr_idx_q, wr_idx_d;
    logic              err_early_q, err_early_d;
    logic              err_miss_q, err_miss_d;
    logic [15:0]       blocks_q, blocks_d;
    rd_state_e         state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [PIX_W-1:0]  beat_q, beat_d;
    logic              tr_q, tr_d;
    logic              ls_q, ls_d;
    logic [NUM_CH-1:0] mask_q, mask_d;

    logic                   wr_hs;
    logic                   ld;
    logic                   last_hs;
    logic                   rd_free;
    logic                   rd_done;
    logic                   issue;
    logic [CH_W-1:0]        issue_ch;
    logic [PIX_W-1:0]       issue_beat;
    logic [OUT_WIDTH-1:0]   issue_data;
    logic                   issue_last;
    logic [PIX_W-1:0]       rd_addr;
    logic [INPUT_WIDTH-1:0] raw;
    logic                   tr_eff;
    logic                   ls_eff;
    logic [NUM_CH-1:0]      mask_eff;
    logic                   sel_found;
    logic [CH_W-1:0]        sel_ch;

    assign s_axis_tready = alive_q && !full_q[wr_bank_q];
    assign wr_hs   = s_axis_tvalid && s_axis_tready;
    assign last_hs = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // Write side
    always_comb begin
        alive_d     = 1'b1;
        full_d      = full_q;
        wr_bank_d   = wr_bank_q;
        wr_idx_d    = wr_idx_q;
        err_early_d = 1'b0;
        err_miss_d  = 1'b0;
        if (wr_hs) begin
            if (wr_idx_q == LAST_PIX) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d  = !wr_bank_q;
                wr_idx_d   = '0;
                err_miss_d = !s_axis_tlast;
            end else if (s_axis_tlast) begin
                err_early_d = 1'b1;
                wr_idx_d    = '0;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
        if (rd_free) full_d[rd_bank_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_hs) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mem_q[wr_bank_q][c][wr_idx_q] <=
                    s_axis_tdata[c*INPUT_WIDTH +: INPUT_WIDTH];
            end
        end
    end

    // LOAD issues beat 0 from the live cfg so the first beat
    // leaves two cycles after the bank fills.
    assign tr_eff   = (state_q == RD_LOAD) ? cfg_transpose   : tr_q;
    assign ls_eff   = (state_q == RD_LOAD) ? cfg_level_shift : ls_q;
    assign mask_eff = (state_q == RD_LOAD) ? cfg_ch_mask     : mask_q;

    // LOAD: lowest enabled channel; NEXT_CH: next one above ch_q
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (!sel_found && mask_eff[c] &&
                (state_q == RD_LOAD || CH_W'(c) > ch_q)) begin
                sel_found = 1'b1;
                sel_ch    = CH_W'(c);
            end
        end
    end

    // Read FSM: state register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= RD_IDLE;
        else          state_q <= state_d;
    end

    // Read FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) state_d = RD_LOAD;
            end
            RD_LOAD: begin
                if (!sel_found) state_d = RD_IDLE;
                else if (ld)    state_d = RD_STREAM;
            end
            RD_STREAM: begin
                if (ld && beat_q == LAST_PIX) state_d = RD_NEXT_CH;
            end
            RD_NEXT_CH: begin
                if (sel_found) begin
                    if (ld) state_d = RD_STREAM;
                end else if (last_hs) begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Read FSM: outputs
    always_comb begin
        issue      = 1'b0;
        issue_ch   = ch_q;
        issue_beat = beat_q;
        ch_d       = ch_q;
        beat_d     = beat_q;
        tr_d       = tr_q;
        ls_d       = ls_q;
        mask_d     = mask_q;
        rd_free    = 1'b0;
        rd_done    = 1'b0;
        unique case (state_q)
            RD_IDLE: ;
            RD_LOAD: begin
                tr_d   = cfg_transpose;
                ls_d   = cfg_level_shift;
                mask_d = cfg_ch_mask;
                if (!sel_found) begin
                    rd_free = 1'b1;
                end else if (ld) begin
                    issue      = 1'b1;
                    issue_ch   = sel_ch;
                    issue_beat = '0;
                    ch_d       = sel_ch;
                    beat_d     = PIX_W'(1);
                end
            end
            RD_STREAM: begin
                if (ld) begin
                    issue  = 1'b1;
                    beat_d = (beat_q == LAST_PIX) ? '0 : beat_q + 1'b1;
                end
            end
            RD_NEXT_CH: begin
                if (sel_found) begin
                    if (ld) begin
                        issue      = 1'b1;
                        issue_ch   = sel_ch;
                        issue_beat = '0;
                        ch_d       = sel_ch;
                        beat_d     = PIX_W'(1);
                    end
                end else if (last_hs) begin
                    rd_free = 1'b1;
                    rd_done = 1'b1;
                end
            end
            default: ;
        endcase
        rd_bank_d = rd_bank_q ^ rd_free;
        blocks_d  = blocks_q + 16'(rd_done);
    end

    // Readout address and sample formatting
    always_comb begin
        int row;
        int col;
        row = int'(issue_beat) / DATA_DEPTH;
        col = int'(issue_beat) % DATA_DEPTH;
        if (tr_eff) rd_addr = PIX_W'(col * DATA_DEPTH + row);
        else        rd_addr = PIX_W'(row * DATA_DEPTH + col);
        raw = mem_q[rd_bank_q][issue_ch][rd_addr];
        if (ls_eff)
            issue_data = OUT_WIDTH'(
                level_shift(64'(raw), INPUT_WIDTH, OUT_WIDTH));
        else
            issue_data = OUT_WIDTH'(raw);
        issue_last = (issue_beat == LAST_PIX);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            alive_q     <= 1'b0;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            err_early_q <= 1'b0;
            err_miss_q  <= 1'b0;
            blocks_q    <= '0;
            ch_q        <= CH_W'(CH_Y);
            beat_q      <= '0;
            tr_q        <= 1'b0;
            ls_q        <= 1'b0;
            mask_q      <= '0;
        end else begin
            alive_q     <= alive_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_idx_q    <= wr_idx_d;
            err_early_q <= err_early_d;
            err_miss_q  <= err_miss_d;
            blocks_q    <= blocks_d;
            ch_q        <= ch_d;
            beat_q      <= beat_d;
            tr_q        <= tr_d;
            ls_q        <= ls_d;
            mask_q      <= mask_d;
        end
    end

    axis_out_reg #(
        .DW (OUT_WIDTH),
        .UW (CH_W)
    ) u_out (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (issue),
        .in_data   (issue_data),
        .in_user   (issue_ch),
        .in_last   (issue_last),
        .in_ready  (ld),
        .out_valid (m_axis_tvalid),
        .out_data  (m_axis_tdata),
        .out_user  (m_axis_tuser),
        .out_last  (m_axis_tlast),
        .out_ready (m_axis_tready)
    );

    assign err_tlast_early = err_early_q;
    assign err_tlast_miss  = err_miss_q;
    assign blocks_out      = blocks_q;

endmodule
